// File: rtl/uart_pkg.sv
// uart_pkg: receiver FSM state type and elaboration-time helpers for uart_rx_fifo.
package uart_pkg;
   typedef enum logic [2:0] {
      IDLE,
      START,
      DATA,
`ifdef UART_RX_PARITY_EN
      PARITY,
`endif
      STOP,
      BREAK
   } rx_state_e;
   function automatic int baud_div(input int clk_hz, input int baud);
      return (clk_hz + baud / 2) / baud;
   endfunction
   function automatic int bits_for(input int n);
      return (n < 1) ? 1 : $clog2(n + 1);
   endfunction
endpackage

// File: rtl/sync_fifo.sv
// sync_fifo: first-word-fall-through synchronous FIFO.
// Ports: CLK/RST (sync active-high), wr_en/wr_data push, rd_en pop,
//        rd_data head (0 when empty), count occupancy, full, empty.
// A push into a full FIFO is accepted only when a pop happens in the same cycle.
module sync_fifo #(
   parameter int WIDTH = 8,
   parameter int DEPTH = 16
) (
   input  logic                     CLK,
   input  logic                     RST,
   input  logic                     wr_en,
   input  logic [WIDTH-1:0]         wr_data,
   input  logic                     rd_en,
   output logic [WIDTH-1:0]         rd_data,
   output logic [$clog2(DEPTH):0]   count,
   output logic                     full,
   output logic                     empty
);
   localparam int AW = $clog2(DEPTH);
   logic [WIDTH-1:0] mem_q [DEPTH];
   logic [AW-1:0] wp_q, rp_q;
   logic [AW:0] cnt_q;
   logic wr_ok, rd_ok;
   assign empty = cnt_q == '0;
   assign full = cnt_q == (AW+1)'(DEPTH);
   assign rd_ok = rd_en && !empty;
   assign wr_ok = wr_en && (!full || rd_en);
   assign rd_data = empty ? '0 : mem_q[rp_q];
   assign count = cnt_q;
   always_ff @(posedge CLK) begin
      if (wr_ok) mem_q[wp_q] <= wr_data;
   end
   always_ff @(posedge CLK) begin
      if (RST) begin
         wp_q <= '0;
         rp_q <= '0;
         cnt_q <= '0;
      end else begin
         if (wr_ok) wp_q <= wp_q + 1'b1;
         if (rd_ok) rp_q <= rp_q + 1'b1;
         cnt_q <= cnt_q + (AW+1)'(wr_ok) - (AW+1)'(rd_ok);
      end
   end
endmodule

// File: rtl/uart_rx_fifo.sv
// uart_rx_fifo: UART receiver (LSB first, 1 stop bit) feeding a FWFT receive FIFO.
// Ports: CLK/RST (sync active-high), rx_in serial line, rd_en pop, rd_data/rd_valid head,
//        fifo_count occupancy, frame_err/parity_err/overrun one-cycle pulses, irq level.
// Macro UART_RX_PARITY_EN adds one parity bit (PARITY_ODD selects odd); otherwise parity_err is 0.
module uart_rx_fifo
   import uart_pkg::*;
#(
   parameter int CLOCK_FREQ = 10000000,
   parameter int BAUD       = 115200,
   parameter int DATA_BITS  = 8,
   parameter int FIFO_DEPTH = 16,
   parameter int IRQ_THRESH = 1,
   parameter int PARITY_ODD = 0
) (
   input  logic                          CLK,
   input  logic                          RST,
   input  logic                          rx_in,
   input  logic                          rd_en,
   output logic [DATA_BITS-1:0]          rd_data,
   output logic                          rd_valid,
   output logic [$clog2(FIFO_DEPTH):0]   fifo_count,
   output logic                          frame_err,
   output logic                          parity_err,
   output logic                          overrun,
   output logic                          irq
);
   localparam int DIV = baud_div(CLOCK_FREQ, BAUD);
   localparam int CW = bits_for(DIV);
   localparam int BW = bits_for(DATA_BITS);
   localparam int NW = $clog2(FIFO_DEPTH) + 1;
   rx_state_e st_q, st_d;
   logic [CW-1:0] cnt_q, cnt_d;
   logic [BW-1:0] bit_q, bit_d;
   logic [DATA_BITS-1:0] sh_q, sh_d;
   logic rx_s1_q, rx_s2_q, rx_prev_q;
   logic rx, tick, push, full, empty, par_bad;
   logic frame_d, frame_q, ovr_q;
`ifdef UART_RX_PARITY_EN
   logic par_bad_q, par_bad_d, parity_d, parity_q;
   assign par_bad = par_bad_q;
   assign parity_err = parity_q;
`else
   assign par_bad = 1'b0;
   assign parity_err = 1'b0;
`endif
   // Synchronizer and edge history are left out of reset so that a line held
   // low across RST is not mistaken for a fresh start edge.
   always_ff @(posedge CLK) begin
      rx_s1_q <= rx_in;
      rx_s2_q <= rx_s1_q;
      rx_prev_q <= rx_s2_q;
   end
   assign rx = rx_s2_q;
   assign tick = cnt_q == '0;
   always_comb begin
      st_d = st_q;
      cnt_d = tick ? CW'(DIV - 1) : cnt_q - 1'b1;
      bit_d = bit_q;
      sh_d = sh_q;
      push = 1'b0;
      frame_d = 1'b0;
`ifdef UART_RX_PARITY_EN
      par_bad_d = par_bad_q;
      parity_d = 1'b0;
`endif
      case (st_q)
         IDLE: if (rx_prev_q && !rx) begin
            st_d = START;
            cnt_d = CW'(DIV / 2);
         end
         START: if (tick) begin
            st_d = rx ? IDLE : DATA;
            bit_d = '0;
`ifdef UART_RX_PARITY_EN
            par_bad_d = 1'b0;
`endif
         end
         DATA: if (tick) begin
            sh_d = {rx, sh_q[DATA_BITS-1:1]};
            bit_d = bit_q + 1'b1;
`ifdef UART_RX_PARITY_EN
            if (bit_q == BW'(DATA_BITS - 1)) st_d = PARITY;
`else
            if (bit_q == BW'(DATA_BITS - 1)) st_d = STOP;
`endif
         end
`ifdef UART_RX_PARITY_EN
         PARITY: if (tick) begin
            par_bad_d = (^sh_q ^ rx) != PARITY_ODD[0];
            st_d = STOP;
         end
`endif
         // Error priority falls out naturally: a bad stop bit masks parity,
         // and a parity failure never pushes, so it can never overrun.
         STOP: if (tick) begin
            st_d = rx ? IDLE : BREAK;
            frame_d = !rx;
            push = rx && !par_bad;
`ifdef UART_RX_PARITY_EN
            parity_d = rx && par_bad;
`endif
         end
         BREAK: if (rx) st_d = IDLE;
         default: st_d = IDLE;
      endcase
   end
   always_ff @(posedge CLK) begin
      if (RST) begin
         st_q <= IDLE;
         cnt_q <= '0;
         bit_q <= '0;
         sh_q <= '0;
         frame_q <= 1'b0;
         ovr_q <= 1'b0;
`ifdef UART_RX_PARITY_EN
         par_bad_q <= 1'b0;
         parity_q <= 1'b0;
`endif
      end else begin
         st_q <= st_d;
         cnt_q <= cnt_d;
         bit_q <= bit_d;
         sh_q <= sh_d;
         frame_q <= frame_d;
         ovr_q <= push && full && !rd_en;
`ifdef UART_RX_PARITY_EN
         par_bad_q <= par_bad_d;
         parity_q <= parity_d;
`endif
      end
   end
   sync_fifo #(.WIDTH(DATA_BITS), .DEPTH(FIFO_DEPTH)) u_fifo (
      .CLK(CLK),
      .RST(RST),
      .wr_en(push),
      .wr_data(sh_q),
      .rd_en(rd_en),
      .rd_data(rd_data),
      .count(fifo_count),
      .full(full),
      .empty(empty)
   );
   assign rd_valid = !empty;
   assign frame_err = frame_q;
   assign overrun = ovr_q;
   assign irq = fifo_count >= NW'(IRQ_THRESH);
endmodule
